// File: rtl/vid_tpg_pkg.sv
// Shared types and constants for the clocked-video test pattern source.
package vid_tpg_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned OVF_W = 16;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FCNT  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Bar 0 sits in the low bits, so the list runs from bar 7 down to bar 0.
  localparam logic [7:0][PIX_W-1:0] BAR_COLOURS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/vid_tpg_cvi_source_if.sv
// Clocked-video output bundle driven by the pattern source.
interface vid_tpg_cvi_source_if;
  import vid_tpg_pkg::*;

  logic [PIX_W-1:0] vid_data;
  logic             vid_datavalid;
  logic             vid_h_sync;
  logic             vid_v_sync;
  logic             vid_f;
  logic             vid_locked;
  logic             frame_start;

  modport master (output vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_f, vid_locked, frame_start);
  modport slave  (input  vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_f, vid_locked, frame_start);
endinterface

// File: rtl/vid_tpg_timing.sv
// Raster h/v counters, porch/sync decode and the run/drain state machine.
module vid_tpg_timing
  import vid_tpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned H_W     = $clog2(H_TOTAL),
  localparam int unsigned V_W     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           run_c,
  output logic           active_c,
  output logic           hs_c,
  output logic           vs_c,
  output logic           fs_c,
  output logic           h_wrap_c,
  output logic           v_wrap_c
);

  state_e         state, state_n;
  logic [H_W-1:0] h_n;
  logic [V_W-1:0] v_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_n;
      h     <= h_n;
      v     <= v_n;
    end
  end

  // Counters only move outside IDLE; DRAIN keeps raster timing intact until frame end.
  always_comb begin
    state_n  = state;
    h_n      = h;
    v_n      = v;
    run_c    = (state != ST_IDLE);
    h_wrap_c = run_c && (h == H_W'(H_TOTAL - 1));
    v_wrap_c = h_wrap_c && (v == V_W'(V_TOTAL - 1));
    active_c = run_c && (h < H_W'(H_ACTIVE)) && (v < V_W'(V_ACTIVE));
    hs_c     = run_c && (h >= H_W'(H_ACTIVE + H_FP)) && (h < H_W'(H_ACTIVE + H_FP + H_SYNC));
    vs_c     = run_c && (v >= V_W'(V_ACTIVE + V_FP)) && (v < V_W'(V_ACTIVE + V_FP + V_SYNC));
    fs_c     = run_c && (h == '0) && (v == '0);

    case (state)
      ST_IDLE:  if (enable) state_n = ST_RUN;
      ST_RUN:   if (!enable) state_n = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)        state_n = ST_RUN;
        else if (v_wrap_c) state_n = ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase

    if (run_c) begin
      h_n = h_wrap_c ? '0 : h + H_W'(1);
      if (h_wrap_c) v_n = v_wrap_c ? '0 : v + V_W'(1);
    end
  end

endmodule

// File: rtl/vid_tpg_cvi_source.sv
// Progressive RGB test pattern source for the clocked-video input, plus receiver overflow counter.
module vid_tpg_cvi_source
  import vid_tpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BP       = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FP       = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 20,
  parameter bit          H_POL      = 1'b1,
  parameter bit          V_POL      = 1'b1,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 enable,
  input  logic [1:0]           pattern_sel,
  input  logic                 ovf_clr,
  input  logic                 overflow,
  vid_tpg_cvi_source_if.master vid,
  output logic [OVF_W-1:0]     ovf_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned BC_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [H_W-1:0]   h;
  logic [V_W-1:0]   v;
  logic             run_c, active_c, hs_c, vs_c, fs_c, h_wrap_c, v_wrap_c;
  logic             origin_c;
  pattern_e         pat_q, pat_c;
  logic [BC_W-1:0]  bar_cnt;
  logic [2:0]       bar_idx;
  logic [7:0]       fcnt;
  logic             seen_wrap;
  logic [PIX_W-1:0] pix_c;

  vid_tpg_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .enable   (enable),
    .h        (h),
    .v        (v),
    .run_c    (run_c),
    .active_c (active_c),
    .hs_c     (hs_c),
    .vs_c     (vs_c),
    .fs_c     (fs_c),
    .h_wrap_c (h_wrap_c),
    .v_wrap_c (v_wrap_c)
  );

  // Pattern select is taken live only at the frame origin, so a frame is never torn.
  always_comb begin
    origin_c = (h == '0) && (v == '0);
    pat_c    = origin_c ? pattern_e'(pattern_sel) : pat_q;
    pix_c    = '0;
    case (pat_c)
      PAT_BARS:  pix_c = BAR_COLOURS[bar_idx];
      PAT_RAMP:  pix_c = {3{8'(h)}};
      PAT_CHECK: pix_c = (1'(h >> CHECK_LOG2) ^ 1'(v >> CHECK_LOG2)) ? 24'hFF_FFFF : '0;
      default:   pix_c = {fcnt, 8'h00, ~fcnt};
    endcase
  end

  // Bar position tracks h with a width counter; frame count and lock history.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pat_q     <= PAT_BARS;
      bar_cnt   <= '0;
      bar_idx   <= '0;
      fcnt      <= '0;
      seen_wrap <= 1'b0;
    end else begin
      if (origin_c) pat_q <= pat_c;
      if (!run_c || h_wrap_c) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (h < H_W'(H_ACTIVE)) begin
        if (bar_cnt == BC_W'(BAR_W - 1)) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + BC_W'(1);
        end
      end
      if (v_wrap_c) fcnt <= fcnt + 8'd1;
      if (!run_c)        seen_wrap <= 1'b0;
      else if (v_wrap_c) seen_wrap <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vid.vid_data      <= '0;
      vid.vid_datavalid <= 1'b0;
      vid.vid_h_sync    <= ~H_POL;
      vid.vid_v_sync    <= ~V_POL;
      vid.vid_f         <= 1'b0;
      vid.vid_locked    <= 1'b0;
      vid.frame_start   <= 1'b0;
    end else begin
      vid.vid_data      <= active_c ? pix_c : '0;
      vid.vid_datavalid <= active_c;
      vid.vid_h_sync    <= hs_c ? H_POL : ~H_POL;
      vid.vid_v_sync    <= vs_c ? V_POL : ~V_POL;
      vid.vid_f         <= 1'b0;
      vid.vid_locked    <= seen_wrap && run_c;
      vid.frame_start   <= fs_c;
    end
  end

  // Saturating overflow counter; clear wins over a coincident pulse.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (overflow && (ovf_count != '1)) begin
      ovf_count <= ovf_count + OVF_W'(1);
    end
  end

endmodule

// File: tb/tb_vid_tpg_cvi_source.sv
// Bench for vid_tpg_cvi_source: small raster, reference model of pixels/syncs/lock/overflow.
module tb_vid_tpg_cvi_source;

  localparam int T_HA = 16, T_HFP = 2, T_HS = 3, T_HBP = 3;
  localparam int T_VA = 4,  T_VFP = 1, T_VS = 2, T_VBP = 1;
  localparam int T_HT = T_HA + T_HFP + T_HS + T_HBP;
  localparam int T_VT = T_VA + T_VFP + T_VS + T_VBP;
  localparam int FRAME = T_HT * T_VT;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_n, enable, ovf_clr, overflow;
  logic [1:0]  sel;
  logic [15:0] ovf_count;

  int total = 0, bad = 0;
  int pos = 0, pat_m = 0, fcnt_m = 0, ovf_m = 0, n_dv = 0, n_fs = 0;
  bit locked_m = 1'b0, rand_ovf = 1'b0;

  vid_tpg_cvi_source_if vif ();

  vid_tpg_cvi_source #(
    .H_ACTIVE (T_HA), .H_FP (T_HFP), .H_SYNC (T_HS), .H_BP (T_HBP),
    .V_ACTIVE (T_VA), .V_FP (T_VFP), .V_SYNC (T_VS), .V_BP (T_VBP),
    .H_POL (1'b1), .V_POL (1'b1), .CHECK_LOG2 (1)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .enable        (enable),
    .pattern_sel   (sel),
    .ovf_clr       (ovf_clr),
    .overflow      (overflow),
    .vid           (vif),
    .ovf_count     (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {2'b00, vif.vid_data, vif.vid_datavalid, vif.vid_h_sync, vif.vid_v_sync,
            vif.vid_f, vif.vid_locked, vif.frame_start};
  endfunction

  // Expected output word for raster position p, computed straight from the pattern rules.
  function automatic logic [31:0] model_vec(input int p);
    int h = p % T_HT;
    int v = p / T_HT;
    bit act = (h < T_HA) && (v < T_VA);
    bit hs = (h >= T_HA + T_HFP) && (h < T_HA + T_HFP + T_HS);
    bit vs = (v >= T_VA + T_VFP) && (v < T_VA + T_VFP + T_VS);
    logic [23:0] pix;
    case (pat_m)
      0:       pix = BARS[h / (T_HA / 8)];
      1:       pix = {3{8'(h)}};
      2:       pix = (((h >> 1) ^ (v >> 1)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      default: pix = {8'(fcnt_m), 8'h00, ~8'(fcnt_m)};
    endcase
    if (!act) pix = 24'h0;
    return {2'b00, pix, act, hs, vs, 1'b0, locked_m, p == 0};
  endfunction

  task automatic drive_ovf();
    if (rand_ovf) begin
      overflow = ($urandom_range(0, 3) == 0);
      ovf_clr  = ($urandom_range(0, 31) == 0);
      if (ovf_clr) ovf_m = 0;
      else if (overflow && ovf_m < 65535) ovf_m++;
    end
  endtask

  task automatic expect_active(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pos == 0) pat_m = int'(sel);
      chk($sformatf("vid@%0d", pos), obs_vec(), model_vec(pos));
      chk("ovf_count", 32'(ovf_count), 32'(ovf_m));
      n_dv += int'(vif.vid_datavalid);
      n_fs += int'(vif.frame_start);
      pos++;
      if (pos == FRAME) begin
        pos = 0;
        fcnt_m++;
        locked_m = 1'b1;
      end
      drive_ovf();
    end
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle", obs_vec(), 32'h0);
      chk("ovf_count", 32'(ovf_count), 32'(ovf_m));
      drive_ovf();
    end
  endtask

  // Raise enable: one edge enters RUN, the next shows pixel (0,0).
  task automatic start_run();
    enable = 1'b1;
    expect_idle(1);
    pos = 0;
    locked_m = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sel = 2'd0; ovf_clr = 1'b0; overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vid", obs_vec(), 32'h0);
    chk("reset_ovf", 32'(ovf_count), 32'h0);
    rst_n = 1'b1;
    rand_ovf = 1'b1;
    expect_idle(3);

    // Three bar frames, checking raster timing and lock rise at the second frame start.
    start_run();
    expect_active(3 * FRAME);
    chk("dv_count", 32'(n_dv), 32'(3 * T_HA * T_VA));
    chk("fs_count", 32'(n_fs), 32'd3);

    // Switching to ramp at line 2 keeps bars for the rest of that frame.
    sel = 2'd0;
    expect_active(2 * T_HT);
    sel = 2'd1;
    expect_active(FRAME - 2 * T_HT);
    expect_active(FRAME);

    // Drain: enable dropped with the raster at (5,1), output runs to frame end then idles.
    sel = 2'($urandom_range(0, 3));
    expect_active(T_HT + 5);
    enable = 1'b0;
    expect_active(FRAME - (T_HT + 5));
    expect_idle(4);

    // Drain cancelled at line 3: timing continues without a gap.
    sel = 2'($urandom_range(0, 3));
    start_run();
    expect_active(T_HT + 5);
    enable = 1'b0;
    expect_active(2 * T_HT);
    enable = 1'b1;
    expect_active(FRAME - 3 * T_HT - 5);
    expect_active(FRAME);

    // Asynchronous reset with the raster at (10,2).
    expect_active(2 * T_HT + 10);
    rand_ovf = 1'b0; overflow = 1'b0; ovf_clr = 1'b0;
    rst_n = 1'b0; enable = 1'b0;
    #1;
    chk("midreset_vid", obs_vec(), 32'h0);
    chk("midreset_ovf", 32'(ovf_count), 32'h0);
    ovf_m = 0; fcnt_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_ovf = 1'b1;
    start_run();

    // Random pattern changes across several frames, including frame-count colour.
    for (int k = 0; k < 8; k++) begin
      expect_active(int'($urandom_range(20, 200)));
      sel = 2'($urandom_range(0, 3));
    end

    // Directed overflow counter checks.
    rand_ovf = 1'b0;
    overflow = 1'b0; ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf_count), 32'h0);
    overflow = 1'b1;
    repeat (3) @(negedge clk);
    overflow = 1'b0;
    @(negedge clk);
    chk("ovf_three", 32'(ovf_count), 32'd3);
    overflow = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr_priority", 32'(ovf_count), 32'h0);
    repeat (65534) @(negedge clk);
    chk("ovf_fffe", 32'(ovf_count), 32'hFFFE);
    repeat (1000) @(negedge clk);
    chk("ovf_saturate", 32'(ovf_count), 32'hFFFF);
    overflow = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vid_tpg_cvi_source.md
# vid_tpg_cvi_source

- Source side of the clocked-video input path: generates a progressive RGB test pattern with full sync timing.
- Drives the clocked-video input ports of the video subsystem (vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_f, vid_locked) on the video input clock.
- Pattern select comes from the 2-bit PIO export.
- Also counts overflow pulses returned by the receiver, so firmware can confirm the source/receiver pair keeps up.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line (multiple of 8)
- H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal porch and sync widths in pixels
- V_ACTIVE, 720, active lines per frame
- V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical porch and sync widths in lines
- H_POL / V_POL, 1 / 1, sync polarity; 1 = active-high
- CHECK_LOG2, 5, checkerboard square size is 2^CHECK_LOG2 pixels

Ports:
- clk_clk  in  1  pixel clock; the only clock
- reset_reset_n  in  1  reset; asynchronous assert, active-low
- enable  in  1  run request
- pattern_sel  in  2  0 colour bars, 1 grey ramp, 2 checkerboard, 3 frame-count colour
- ovf_clr  in  1  single-cycle clear of ovf_count
- overflow  in  1  overflow pulse from the receiver
- vid_data  out  24  pixel data as {R[23:16], G[15:8], B[7:0]}
- vid_datavalid  out  1  active pixel
- vid_h_sync / vid_v_sync  out  1 each  syncs, polarity set by H_POL / V_POL
- vid_f  out  1  field; tied to 0 (progressive only)
- vid_locked  out  1  timing stable
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0) on the outputs
- ovf_count  out  16  saturating overflow count

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL similarly.
  - h counts 0..H_TOTAL-1 and wraps.
  - v increments when h wraps and wraps at V_TOTAL-1.
- Line order: active, front porch, sync, back porch. Frame order is the same.
- vid_datavalid = (h < H_ACTIVE) && (v < V_ACTIVE).
- h_sync is active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- v_sync is active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC and changes only together with h = 0.
- vid_data is 0 whenever vid_datavalid = 0.
- Patterns:
  - Bars: 8 bars of width H_ACTIVE/8, in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Use a bar-width counter, not a divider.
  - Ramp: R=G=B = h[7:0].
  - Checker: FFFFFF if h[CHECK_LOG2]^v[CHECK_LOG2], else 000000.
  - Frame-count colour: {fcnt[7:0], 8'h00, ~fcnt[7:0]}, where fcnt is an 8-bit wrapping count of completed frames.
- pattern_sel is latched only when h = 0 and v = 0. A change mid-frame never tears the current frame.
- State machine:
  - IDLE: counters held at 0; all outputs inactive. Moves to RUN when enable = 1.
  - RUN: counters advance. If enable = 0 is sampled in RUN, go to DRAIN.
  - DRAIN: counters advance until the last pixel of the frame (h = H_TOTAL-1, v = V_TOTAL-1), then go to IDLE. If enable returns to 1 during DRAIN, go back to RUN with no timing discontinuity.
- vid_locked:
  - 0 in IDLE.
  - Set when the first full frame after leaving IDLE completes (first v wrap).
  - Stays set through DRAIN; cleared on entering IDLE.
- ovf_count:
  - Increments on each overflow = 1 cycle and saturates at FFFF.
  - ovf_clr takes priority: clear and overflow in the same cycle gives 0.
  - Counts in every state.

## Timing
- Reset values: vid_data 0, vid_datavalid 0, vid_h_sync = ~H_POL, vid_v_sync = ~V_POL, vid_f 0, vid_locked 0, frame_start 0, ovf_count 0. State is IDLE.
- All video outputs are registered and reflect the counter state with 1 cycle of latency. All outputs change together, so they are mutually aligned.
- Startup: the edge that samples enable = 1 in IDLE enters RUN with (h,v) = (0,0). Pixel (0,0) and frame_start appear on the outputs at the following edge.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously). Restart follows the startup rule.
- ovf_count updates 1 cycle after the overflow sample.

## Structure
- Package vid_tpg_pkg holds:
  - the pattern-select enum;
  - the state enum (IDLE/RUN/DRAIN);
  - the 8 bar colour constants.
- Sub-module vid_tpg_timing:
  - contains the h/v counters, porch/sync decode and the state machine;
  - outputs h, v, active, hs, vs, frame-start and wrap strobes.
- Top level adds pattern generation, the output registers, locked logic and the overflow counter.

## Test plan
Small bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL 24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL 8); CHECK_LOG2=1.

- Timing: enable=1 held for 3 frames.
  - datavalid is high for 16 of every 24 cycles on lines 0-3.
  - h_sync is high at h = 18-20.
  - v_sync is high for lines 5-6.
  - frame_start period is 192 cycles; vid_locked rises after cycle 192.
- Colour bars: pattern_sel=0 gives pixels 0-1 = FFFFFF, 2-3 = FFFF00, …, 14-15 = 000000.
- Pattern change mid-frame: switching pattern_sel 0→1 at line 2 leaves the rest of that frame as bars. The next frame carries the ramp 00..0F.
- Drain: enable dropped at (h,v) = (5,1).
  - Output continues to the frame end (h,v) = (23,7), then all outputs go idle and vid_locked = 0.
  - Repeat with enable re-raised at line 3: no gap in timing.
- Reset mid-frame: asserting reset_reset_n low at (10,2) forces outputs to reset values asynchronously. After release and enable, the first frame_start arrives 1 cycle after RUN entry.
- Overflow counter:
  - 3 overflow pulses give ovf_count = 3.
  - Overflow and ovf_clr in the same cycle give 0.
  - 70000 pulses give FFFF (saturation).
